// File: rtl/booth4_mul_iter_pkg.sv
// booth4_pkg: shared types and sizing for the radix-4 Booth multipliers.
package booth4_pkg;
    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_code_e;
    function automatic int ngrp(input int width_r);
        return (width_r + 2) / 2;
    endfunction
endpackage

// File: rtl/booth4_mul_iter_if.sv
// booth4_mul_iter_if: operand/result bundle of the iterative Booth multiplier.
interface booth4_mul_iter_if #(parameter int WIDTH_M = 8, parameter int WIDTH_R = 8);
    logic                       vld_in;
    logic                       rdy_in;
    logic                       sgn_in;
    logic [WIDTH_M-1:0]         multiplicand;
    logic [WIDTH_R-1:0]         multiplier;
    logic [WIDTH_M+WIDTH_R-1:0] mul_out;
    logic                       done;
    modport master (output vld_in, sgn_in, multiplicand, multiplier, input rdy_in, mul_out, done);
    modport slave  (input vld_in, sgn_in, multiplicand, multiplier, output rdy_in, mul_out, done);
endinterface

// File: rtl/booth4_mul_iter_pp_sel.sv
// booth4_pp_sel: radix-4 Booth partial-product selector; negation is ~mag with neg as carry-in.
module booth4_pp_sel
    import booth4_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [2:0]   grp,
    input  logic [W-1:0] a,
    output logic [W-1:0] pp,
    output logic         neg
);
    booth_code_e  code;
    logic [W-1:0] mag;
    always_comb begin
        code = (grp == 3'b001 || grp == 3'b010) ? POS1 :
               (grp == 3'b011) ? POS2 :
               (grp == 3'b100) ? NEG2 :
               (grp == 3'b101 || grp == 3'b110) ? NEG1 : ZERO;
        mag  = (code == POS2 || code == NEG2) ? {a[W-2:0], 1'b0} : (code == ZERO) ? '0 : a;
        neg  = code == NEG1 || code == NEG2;
        pp   = neg ? ~mag : mag;
    end
endmodule

// File: rtl/booth4_mul_iter.sv
// booth4_mul_iter: iterative radix-4 Booth multiplier, one partial product per clock.
// Define BOOTH4_MUL_ITER_EARLY_TERM_EN to finish as soon as all remaining groups encode zero.
module booth4_mul_iter
    import booth4_pkg::*;
#(
    parameter int WIDTH_M = 8,
    parameter int WIDTH_R = 8
) (
    input logic clk,
    input logic rst,
    booth4_mul_iter_if.slave bus
);
    localparam int NG = ngrp(WIDTH_R);
    localparam int W  = WIDTH_M + 2;
    localparam int YW = 2 * NG + 1;
    localparam int P  = WIDTH_M + WIDTH_R;
    localparam int AW = P + 2;
    localparam int CW = $clog2(NG);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW-1:0]   acc_q, acc_d, acc_sum, pp_ext;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [P-1:0]    mul_q, mul_d;
    logic            done_q, done_d;
    logic [W-1:0]    pp;
    logic            neg, busy, accept, last, rest_zero;
    logic [CW:0]     sh;

    booth4_pp_sel #(.W(W)) u_pp_sel (.grp(y_q[2:0]), .a(a_q), .pp(pp), .neg(neg));

`ifdef BOOTH4_MUL_ITER_EARLY_TERM_EN
    // y_q shifts with sign fill, so uniform upper bits mean every later group is zero
    assign rest_zero = (&y_q[YW-1:2]) || ~(|y_q[YW-1:2]);
`else
    assign rest_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? BUSY : IDLE) : (last ? IDLE : BUSY);
    end

    always_comb begin
        bus.rdy_in  = state_q == IDLE && !rst;
        bus.done    = done_q;
        bus.mul_out = mul_q;
    end

    always_comb begin
        busy    = state_q == BUSY;
        accept  = bus.vld_in && bus.rdy_in;
        sh      = {cnt_q, 1'b0};
        pp_ext  = {{WIDTH_R{pp[W-1]}}, pp};
        acc_sum = acc_q + (pp_ext << sh) + (AW'(neg) << sh);
        last    = busy && (cnt_q == CW'(NG - 1) || rest_zero);
        a_d     = accept ? {{2{bus.sgn_in & bus.multiplicand[WIDTH_M-1]}}, bus.multiplicand} : a_q;
        y_d     = accept ? {{(2*NG-WIDTH_R){bus.sgn_in & bus.multiplier[WIDTH_R-1]}}, bus.multiplier, 1'b0} :
                  busy ? {{2{y_q[YW-1]}}, y_q[YW-1:2]} : y_q;
        acc_d   = accept ? '0 : busy ? acc_sum : acc_q;
        cnt_d   = accept ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
        mul_d   = last ? acc_sum[P-1:0] : mul_q;
        done_d  = last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            mul_q  <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mul_q  <= mul_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_booth4_mul_iter.sv
// tb_booth4_mul_iter: directed and randomised checks of booth4_mul_iter (8x8 and 12x7).
module tb_booth4_mul_iter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth4_mul_iter_if #(.WIDTH_M(8),  .WIDTH_R(8)) b8();
    booth4_mul_iter_if #(.WIDTH_M(12), .WIDTH_R(7)) b12();

    booth4_mul_iter #(.WIDTH_M(8),  .WIDTH_R(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    booth4_mul_iter #(.WIDTH_M(12), .WIDTH_R(7)) dut12 (.clk(clk), .rst(rst), .bus(b12));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected latency: NGRP, or the first group after which all remaining extended bits agree
    function automatic int lat_model(input logic [15:0] b, input int wr, input bit sgn);
        int ng;
        ng = (wr + 2) / 2;
`ifdef BOOTH4_MUL_ITER_EARLY_TERM_EN
        begin
            logic [15:0] e;
            bit u1, u0;
            for (int k = 0; k < 16; k++) e[k] = (k < wr) ? b[k] : (sgn & b[wr-1]);
            for (int j = 0; j < ng - 1; j++) begin
                u1 = 1'b1;
                u0 = 1'b1;
                for (int k = 2 * j + 1; k < 2 * ng; k++) begin
                    u1 = u1 & e[k];
                    u0 = u0 & ~e[k];
                end
                if (u1 || u0) return j + 1;
            end
        end
`endif
        return ng;
    endfunction

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                          output logic [15:0] p, output int lat, output int rdy_busy);
        b8.vld_in = 1'b1;
        b8.multiplicand = a;
        b8.multiplier = b;
        b8.sgn_in = s;
        tick();
        b8.vld_in = 1'b0;
        lat = 0;
        rdy_busy = 0;
        while (b8.done !== 1'b1 && lat < 20) begin
            if (b8.rdy_in !== 1'b0) rdy_busy++;
            tick();
            lat++;
        end
        if (b8.done !== 1'b1) lat = -1;
        p = b8.mul_out;
    endtask

    task automatic do_op12(input logic [11:0] a, input logic [6:0] b, input bit s,
                           output logic [18:0] p, output int lat);
        b12.vld_in = 1'b1;
        b12.multiplicand = a;
        b12.multiplier = b;
        b12.sgn_in = s;
        tick();
        b12.vld_in = 1'b0;
        lat = 0;
        while (b12.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (b12.done !== 1'b1) lat = -1;
        p = b12.mul_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (b8.rdy_in !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", b8.rdy_in); end
        checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", b8.done); end
        checks++; if (b8.mul_out !== 16'h0) begin errors++; $display("FAIL reset_mul_out got %h want 0000", b8.mul_out); end
        rst = 1'b0;
        tick();
        checks++; if (b8.rdy_in !== 1'b1) begin errors++; $display("FAIL reset_rdy_after got %b want 1", b8.rdy_in); end
        checks++; if (b12.rdy_in !== 1'b1) begin errors++; $display("FAIL reset_rdy12_after got %b want 1", b12.rdy_in); end
    endtask

    task automatic test_unsigned();
        logic [15:0] p;
        int lat, rb, el;
        el = lat_model(16'h00FF, 8, 1'b0);
        do_op8(8'hFF, 8'hFF, 1'b0, p, lat, rb);
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL uns_255x255 got %h want fe01", p); end
        checks++; if (lat != el) begin errors++; $display("FAIL uns_latency got %0d want %0d", lat, el); end
        checks++; if (rb != 0) begin errors++; $display("FAIL uns_rdy_busy got %0d high cycles want 0", rb); end
        checks++; if (b8.rdy_in !== 1'b1) begin errors++; $display("FAIL uns_rdy_done got %b want 1", b8.rdy_in); end
        tick();
        checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL uns_done_pulse got %b want 0", b8.done); end
        checks++; if (b8.mul_out !== 16'hFE01) begin errors++; $display("FAIL uns_hold got %h want fe01", b8.mul_out); end
    endtask

    task automatic test_signed();
        logic [7:0]  ta [4] = '{8'h80, 8'h80, 8'h05, 8'h80};
        logic [7:0]  tb [4] = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
        bit          ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] te [4] = '{16'h4000, 16'hC080, 16'hFFFB, 16'h7F80};
        logic [15:0] p;
        int lat, rb, el;
        for (int i = 0; i < 4; i++) begin
            el = lat_model({8'h00, tb[i]}, 8, ts[i]);
            do_op8(ta[i], tb[i], ts[i], p, lat, rb);
            checks++; if (p !== te[i]) begin errors++; $display("FAIL signed_%0d got %h want %h", i, p, te[i]); end
            checks++; if (lat != el) begin errors++; $display("FAIL signed_lat_%0d got %0d want %0d", i, lat, el); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, ndone;
        b8.vld_in = 1'b1;
        b8.multiplicand = 8'h0C;
        b8.multiplier = 8'h0D;
        b8.sgn_in = 1'b0;
        tick();
        n1 = 0;
        while (b8.done !== 1'b1 && n1 < 20) begin tick(); n1++; end
        checks++; if (n1 != lat_model(16'h000D, 8, 1'b0)) begin errors++; $display("FAIL b2b_lat1 got %0d want %0d", n1, lat_model(16'h000D, 8, 1'b0)); end
        checks++; if (b8.mul_out !== 16'h009C) begin errors++; $display("FAIL b2b_p1 got %h want 009c", b8.mul_out); end
        b8.multiplicand = 8'h21;
        b8.multiplier = 8'h03;
        tick();
        b8.vld_in = 1'b0;
        checks++; if (b8.rdy_in !== 1'b0) begin errors++; $display("FAIL b2b_accept_in_done got rdy %b want 0", b8.rdy_in); end
        checks++; if (b8.mul_out !== 16'h009C) begin errors++; $display("FAIL b2b_hold got %h want 009c", b8.mul_out); end
        n2 = 1;
        while (b8.done !== 1'b1 && n2 < 20) begin tick(); n2++; end
        checks++; if (n2 != 1 + lat_model(16'h0003, 8, 1'b0)) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", n2, 1 + lat_model(16'h0003, 8, 1'b0)); end
        checks++; if (b8.mul_out !== 16'h0063) begin errors++; $display("FAIL b2b_p2 got %h want 0063", b8.mul_out); end
        ndone = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (b8.done === 1'b1) ndone++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL b2b_extra_done got %0d want 0", ndone); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat, rb, ndone;
        b8.vld_in = 1'b1;
        b8.multiplicand = 8'd200;
        b8.multiplier = 8'd3;
        b8.sgn_in = 1'b0;
        tick();
        b8.vld_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", b8.done); end
        checks++; if (b8.mul_out !== 16'h0) begin errors++; $display("FAIL rstmid_mul_out got %h want 0000", b8.mul_out); end
        checks++; if (b8.rdy_in !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got %b want 0", b8.rdy_in); end
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (b8.done === 1'b1) ndone++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_stale_done got %0d want 0", ndone); end
        do_op8(8'd7, 8'd9, 1'b0, p, lat, rb);
        checks++; if (p !== 16'd63) begin errors++; $display("FAIL rstmid_7x9 got %0d want 63", p); end
        checks++; if (lat != lat_model(16'd9, 8, 1'b0)) begin errors++; $display("FAIL rstmid_lat got %0d want %0d", lat, lat_model(16'd9, 8, 1'b0)); end
        tick();
    endtask

    task automatic test_busy_ignore();
        int n, ndone;
        b8.vld_in = 1'b1;
        b8.multiplicand = 8'hFD;
        b8.multiplier = 8'h07;
        b8.sgn_in = 1'b1;
        tick();
        n = 0;
        while (b8.done !== 1'b1 && n < 20) begin
            b8.vld_in = ~b8.vld_in;
            b8.multiplicand = 8'($urandom);
            b8.multiplier = 8'($urandom);
            b8.sgn_in = ~b8.sgn_in;
            tick();
            n++;
        end
        b8.vld_in = 1'b0;
        checks++; if (b8.mul_out !== 16'hFFEB) begin errors++; $display("FAIL busy_ign_result got %h want ffeb", b8.mul_out); end
        checks++; if (n != lat_model(16'h0007, 8, 1'b1)) begin errors++; $display("FAIL busy_ign_lat got %0d want %0d", n, lat_model(16'h0007, 8, 1'b1)); end
        ndone = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (b8.done === 1'b1) ndone++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL busy_ign_extra got %0d done pulses want 0", ndone); end
        checks++; if (b8.rdy_in !== 1'b1) begin errors++; $display("FAIL busy_ign_rdy got %b want 1", b8.rdy_in); end
    endtask

`ifdef BOOTH4_MUL_ITER_EARLY_TERM_EN
    task automatic test_early_term();
        logic [15:0] p;
        int lat, rb;
        do_op8(8'd100, 8'd3, 1'b0, p, lat, rb);
        checks++; if (p !== 16'h012C) begin errors++; $display("FAIL et_100x3 got %h want 012c", p); end
        checks++; if (lat != 2) begin errors++; $display("FAIL et_lat_100x3 got %0d want 2", lat); end
        tick();
        do_op8(8'd100, 8'd0, 1'b0, p, lat, rb);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL et_100x0 got %h want 0000", p); end
        checks++; if (lat != 1) begin errors++; $display("FAIL et_lat_100x0 got %0d want 1", lat); end
        tick();
    endtask
`endif

    task automatic test_sweep12();
        logic [11:0] a;
        logic [6:0]  b;
        logic [18:0] p, e;
        bit s;
        int lat, el;
        longint av, bv, prod;
        for (int i = 0; i < 2000; i++) begin
            a = 12'($urandom);
            b = 7'($urandom);
            s = 1'($urandom);
            if (s) begin av = $signed(a); bv = $signed(b); end
            else   begin av = a; bv = b; end
            prod = av * bv;
            e = prod[18:0];
            el = lat_model({9'h0, b}, 7, s);
            do_op12(a, b, s, p, lat);
            checks++; if (p !== e) begin errors++; $display("FAIL sweep_%0d %h*%h s=%0d got %h want %h", i, a, b, s, p, e); end
            checks++; if (lat != el) begin errors++; $display("FAIL sweep_lat_%0d got %0d want %0d", i, lat, el); end
            tick();
        end
    endtask

    initial begin
        b8.vld_in = 1'b0;
        b8.sgn_in = 1'b0;
        b8.multiplicand = '0;
        b8.multiplier = '0;
        b12.vld_in = 1'b0;
        b12.sgn_in = 1'b0;
        b12.multiplicand = '0;
        b12.multiplier = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
`ifdef BOOTH4_MUL_ITER_EARLY_TERM_EN
        test_early_term();
`endif
        test_sweep12();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
